pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline hazard / redirect controller for a 6-stage pipeline.
//
// Turns per-stage stall requests, a global ready and an EX-stage branch
// redirect into per-stage hold enables and a wrong-path flush. A small FSM
// (RUN / STALL / FLUSH) tracks whether the pipe is advancing, held on a
// request, or draining wrong-path instructions after a redirect.
//
// Parameters
//   FLUSH_CYCLES  cycles spent in FLUSH after an accepted redirect (1..15)
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous reset, active low
//   rdy           global ready; low freezes the whole pipeline
//   stallreq_if   instruction fetch not yet complete
//   stallreq_id   decode hazard (e.g. load-use)
//   stallreq_mem  data memory access in flight
//   br            EX-stage misprediction redirect, one-cycle pulse
//   stall[5:0]    per-stage hold: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB
//   flush         kill wrong-path contents of IF/ID and ID/EX
//   busy_state    current FSM state: 0 RUN, 1 STALL, 2 FLUSH
//   stall_cycles  count of cycles with the PC held while ready
//
// Configuration
//   PIPE_CTRL_STALL_CNT_EN  when defined, stall_cycles is a saturating
//                           32-bit counter; otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_mem,
    input  logic        br,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [1:0]  busy_state,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       br_pend_q, br_pend_d;

    // The pipe can only move (and a redirect can only be taken) when the
    // whole machine is ready and no memory access is outstanding.
    logic advance;
    logic br_take;

    assign advance = rdy & ~stallreq_mem;
    // A redirect parked while the pipe was frozen counts as a fresh br.
    assign br_take = (br | br_pend_q) & advance;

    // Per-stage hold, first match wins. In FLUSH the IF/ID requests are
    // ignored: the instructions they refer to are being killed anyway.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        stall = 6'b000000;
        if (!rst)                       stall = 6'b000000;
        else if (!rdy)                  stall = 6'b111111;
        else if (stallreq_mem)          stall = 6'b011111;
        else if (state_q == ST_FLUSH)   stall = 6'b000000;
        else if (stallreq_id)           stall = 6'b000111;
        else if (stallreq_if)           stall = 6'b000011;
    end

    assign flush      = rst & ((state_q == ST_FLUSH) | br_take);
    assign busy_state = rst ? state_q : ST_RUN;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        br_pend_d = br_pend_q;
        if (!advance) begin
            // Frozen or waiting on memory: remember a redirect for later.
            // A memory stall seen in RUN still counts as a stall request.
            br_pend_d = br_pend_q | br;
            if (rdy && state_q == ST_RUN) state_d = ST_STALL;
        end else if (br_take) begin
            state_d   = ST_FLUSH;
            cnt_d     = FLUSH_LOAD;
            br_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_RUN:   if (stallreq_if || stallreq_id) state_d = ST_STALL;
                // stallreq_mem is known low on this path.
                ST_STALL: if (!stallreq_if && !stallreq_id) state_d = ST_RUN;
                ST_FLUSH: begin
                    if (cnt_q == 4'd0) state_d = ST_RUN;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= 4'd0;
            br_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            br_pend_q <= br_pend_d;
        end
    end

`ifdef PIPE_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt_q <= 32'd0;
        else if (rdy && stall[0] && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (FLUSH_CYCLES = 2).
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// later and compared with a behavioural model that tracks the pipe as
// "cycles of flush left", "held on a request" and "redirect pending".
// Directed scenarios come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int FC = 2;

    logic        clk;
    logic        rst, rdy, stallreq_if, stallreq_id, stallreq_mem, br;
    logic [5:0]  stall;
    logic        flush;
    logic [1:0]  busy_state;
    logic [31:0] stall_cycles;

    pipe_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .br           (br),
        .stall        (stall),
        .flush        (flush),
        .busy_state   (busy_state),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model
    int          m_left    = 0;   // flush cycles still to run (0 = not flushing)
    bit          m_stalled = 0;   // held on a stall request
    bit          m_pend    = 0;   // redirect waiting for the pipe to move
    logic [31:0] m_cnt     = 0;
    bit          cnt_known = 0;   // stall_cycles defined once reset has been seen

    // Last sampled outputs, for the directed expectations
    logic [5:0]  obs_stall;
    logic        obs_flush;
    logic [1:0]  obs_busy;
    logic [31:0] obs_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic rd, input logic sif,
                       input logic sid, input logic smem, input logic b);
        logic [5:0] e_stall;
        logic       e_flush;
        logic [1:0] e_busy;
        @(negedge clk);
        rst = r; rdy = rd; stallreq_if = sif; stallreq_id = sid;
        stallreq_mem = smem; br = b;
        #1;
        if (!r)                e_stall = 6'd0;
        else if (!rd)          e_stall = 6'd63;
        else if (smem)         e_stall = 6'd31;
        else if (m_left > 0)   e_stall = 6'd0;
        else if (sid)          e_stall = 6'd7;
        else if (sif)          e_stall = 6'd3;
        else                   e_stall = 6'd0;
        e_flush = r && (m_left > 0 || ((b || m_pend) && rd && !smem));
        e_busy  = !r ? 2'd0 : (m_left > 0) ? 2'd2 : m_stalled ? 2'd1 : 2'd0;
        obs_stall = stall; obs_flush = flush; obs_busy = busy_state; obs_cnt = stall_cycles;
        chk("stall", {26'd0, stall}, {26'd0, e_stall});
        chk("flush", {31'd0, flush}, {31'd0, e_flush});
        chk("busy_state", {30'd0, busy_state}, {30'd0, e_busy});
        if (cnt_known) chk("stall_cycles", stall_cycles, m_cnt);
        @(posedge clk);
        if (!r) begin
            m_left = 0; m_stalled = 0; m_pend = 0; m_cnt = 0; cnt_known = 1;
        end else begin
`ifdef PIPE_CTRL_STALL_CNT_EN
            if (rd && e_stall[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
            if (!rd) begin
                m_pend = m_pend | b;
            end else if (smem) begin
                m_pend = m_pend | b;
                if (m_left == 0) m_stalled = 1;
            end else if (b || m_pend) begin
                m_left = FC; m_stalled = 0; m_pend = 0;
            end else if (m_left > 0) begin
                m_left--;
            end else begin
                m_stalled = sif | sid;
            end
        end
    endtask

    task automatic idle();
        cyc(1, 1, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 0; rdy = 1; stallreq_if = 0; stallreq_id = 0; stallreq_mem = 0; br = 0;

        // Reset with every request high, then release into a memory stall
        repeat (3) begin
            cyc(0, 1, 1, 1, 1, 1);
            chk("rst_stall", {26'd0, obs_stall}, 32'h0);
            chk("rst_flush", {31'd0, obs_flush}, 32'h0);
            chk("rst_busy",  {30'd0, obs_busy},  32'h0);
        end
        cyc(1, 1, 1, 1, 1, 0);
        chk("release_stall", {26'd0, obs_stall}, 32'h1F);
        idle(); idle();

        // Decode hazard for two cycles
        cyc(1, 1, 0, 1, 0, 0);
        chk("id_stall0", {26'd0, obs_stall}, 32'h07);
        chk("id_busy0",  {30'd0, obs_busy},  32'h0);
        cyc(1, 1, 0, 1, 0, 0);
        chk("id_stall1", {26'd0, obs_stall}, 32'h07);
        chk("id_busy1",  {30'd0, obs_busy},  32'h1);
        idle();
        chk("id_busy_rel", {30'd0, obs_busy}, 32'h1);
        idle();
        chk("id_busy_run", {30'd0, obs_busy}, 32'h0);

        // Redirect: br cycle plus two FLUSH cycles, fetch stalls masked
        cyc(1, 1, 0, 0, 0, 1);
        chk("br_flush", {31'd0, obs_flush}, 32'h1);
        repeat (2) begin
            cyc(1, 1, 1, 0, 0, 0);
            chk("fl_flush", {31'd0, obs_flush}, 32'h1);
            chk("fl_busy",  {30'd0, obs_busy},  32'h2);
            chk("fl_stall", {26'd0, obs_stall}, 32'h0);
        end
        idle();
        chk("fl_done_flush", {31'd0, obs_flush}, 32'h0);
        chk("fl_done_busy",  {30'd0, obs_busy},  32'h0);

        // Redirect under a memory stall is parked until memory completes
        cyc(1, 1, 0, 0, 1, 1);
        chk("pend_flush0", {31'd0, obs_flush}, 32'h0);
        repeat (2) begin
            cyc(1, 1, 0, 0, 1, 0);
            chk("pend_flush", {31'd0, obs_flush}, 32'h0);
        end
        idle();
        chk("pend_take", {31'd0, obs_flush}, 32'h1);
        idle();
        chk("pend_fl0", {30'd0, obs_busy}, 32'h2);
        idle();
        chk("pend_fl1", {30'd0, obs_busy}, 32'h2);
        idle();
        chk("pend_run", {30'd0, obs_busy}, 32'h0);

        // Freeze in FLUSH, then finish the remaining flush cycles
        cyc(1, 1, 0, 0, 0, 1);
        repeat (4) begin
            cyc(1, 0, 0, 0, 0, 0);
            chk("frz_stall", {26'd0, obs_stall}, 32'h3F);
            chk("frz_busy",  {30'd0, obs_busy},  32'h2);
        end
        idle();
        chk("frz_res0", {30'd0, obs_busy}, 32'h2);
        idle();
        chk("frz_res1", {30'd0, obs_busy}, 32'h2);
        idle();
        chk("frz_run",  {30'd0, obs_busy}, 32'h0);

        // Stall counter: five memory-stall cycles after a fresh reset
        cyc(0, 1, 0, 0, 0, 0);
        repeat (5) cyc(1, 1, 0, 0, 1, 0);
        idle();
`ifdef PIPE_CTRL_STALL_CNT_EN
        chk("cnt_five", obs_cnt, 32'd5);
        dut.stall_cnt_q = 32'hFFFF_FFFD;
        m_cnt           = 32'hFFFF_FFFD;
        repeat (5) cyc(1, 1, 0, 0, 1, 0);
        idle();
        chk("cnt_sat", obs_cnt, 32'hFFFF_FFFF);
`else
        chk("cnt_off", obs_cnt, 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) >= 3),
                ($urandom_range(0, 99) >= 15),
                ($urandom_range(0, 99) < 20),
                ($urandom_range(0, 99) < 20),
                ($urandom_range(0, 99) < 20),
                ($urandom_range(0, 99) < 15));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
